// File: rtl/orpsoc_multi_rst_seq.sv
// Reset sequencer for the multi-core SoC: holds the fabric in reset, then releases
// cores one at a time, and supports per-core and global software re-reset.

module orpsoc_multi_rst_lane #(
  parameter int CW  = 4,
  parameter int CYC = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_rel,
  input  logic i_run,
  input  logic i_req,
  output logic o_rst,
  output logic o_nxt
);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          w_nxt;

  // Priority: global clear, sequencer release, software request, pulse countdown.
  always_comb begin
    w_nxt = o_rst;
    w_cnt = r_cnt;
    if (i_clr) begin
      w_nxt = 1'b1;
      w_cnt = '0;
    end else if (i_rel) begin
      w_nxt = 1'b0;
    end else if (i_run && i_req) begin
      w_nxt = 1'b1;
      w_cnt = CW'(CYC);
    end else if (r_cnt != '0) begin
      w_cnt = r_cnt - 1'b1;
      if (r_cnt == CW'(1)) w_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rst <= 1'b1;
      r_cnt <= '0;
    end else begin
      o_rst <= w_nxt;
      r_cnt <= w_cnt;
    end
  end

  assign o_nxt = w_nxt;
endmodule

module orpsoc_multi_rst_seq #(
  parameter int NUM_CORES       = 2,
  parameter int RST_HOLD        = 50,
  parameter int STAGGER         = 4,
  parameter int CORE_RST_CYCLES = 8,
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 sys_rst_req_i,
  input  logic [NUM_CORES-1:0] core_rst_req_i,
  output logic                 sys_rst_o,
  output logic [NUM_CORES-1:0] core_rst_o,
  output logic                 busy_o,
  output logic [IW-1:0]        cur_core_o,
  output logic                 all_running_o
);
  localparam int MAX_HS = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
  localparam int MAXV   = (MAX_HS > CORE_RST_CYCLES) ? MAX_HS : CORE_RST_CYCLES;
  localparam int CW     = $clog2(MAXV + 1);

  typedef enum logic [1:0] {S_HOLD, S_STAG, S_RUN} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  w_rel;
  logic                  w_last;
  logic                  w_run;
  logic                  w_run_nxt;
  logic [NUM_CORES-1:0]  w_rel_vec;
  logic [NUM_CORES-1:0]  w_core_nxt;

  assign w_rel     = (r_state == S_STAG) && (r_cnt == CW'(STAGGER - 1));
  assign w_last    = (cur_core_o == IW'(NUM_CORES - 1));
  assign w_run     = (r_state == S_RUN);
  assign w_run_nxt = w_run || (w_rel && w_last);

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_rel
    assign w_rel_vec[k] = w_rel && (cur_core_o == IW'(k));
  end

  orpsoc_multi_rst_lane #(.CW(CW), .CYC(CORE_RST_CYCLES)) u_lane [NUM_CORES-1:0] (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (sys_rst_req_i),
    .i_rel (w_rel_vec),
    .i_run (w_run),
    .i_req (core_rst_req_i),
    .o_rst (core_rst_o),
    .o_nxt (w_core_nxt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || sys_rst_req_i) begin
      r_state       <= S_HOLD;
      r_cnt         <= '0;
      cur_core_o    <= '0;
      sys_rst_o     <= 1'b1;
      busy_o        <= 1'b1;
      all_running_o <= 1'b0;
    end else begin
      // Looks at next-cycle core resets so the flag stays aligned with core_rst_o.
      all_running_o <= w_run_nxt && !(|w_core_nxt);
      case (r_state)
        S_HOLD: begin
          if (r_cnt == CW'(RST_HOLD - 1)) begin
            sys_rst_o <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_STAG;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STAG: begin
          if (w_rel) begin
            r_cnt <= '0;
            if (w_last) begin
              r_state <= S_RUN;
              busy_o  <= 1'b0;
            end else begin
              cur_core_o <= cur_core_o + 1'b1;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_orpsoc_multi_rst_seq.sv
// Directed bench: default 2-core sequencer plus an 8-core fast-stagger instance.

module tb_orpsoc_multi_rst_seq;
  logic       clk = 1'b0;
  logic       a_rst, a_sreq;
  logic [1:0] a_req;
  logic       a_sys, a_busy, a_allrun;
  logic [1:0] a_core;
  logic [0:0] a_cur;

  logic       b_rst, b_sreq;
  logic [7:0] b_req;
  logic       b_sys, b_busy, b_allrun;
  logic [7:0] b_core;
  logic [2:0] b_cur;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  orpsoc_multi_rst_seq u_a (
    .wb_clk_i(clk), .wb_rst_i(a_rst), .sys_rst_req_i(a_sreq), .core_rst_req_i(a_req),
    .sys_rst_o(a_sys), .core_rst_o(a_core), .busy_o(a_busy), .cur_core_o(a_cur),
    .all_running_o(a_allrun)
  );

  orpsoc_multi_rst_seq #(.NUM_CORES(8), .RST_HOLD(1), .STAGGER(1), .CORE_RST_CYCLES(3)) u_b (
    .wb_clk_i(clk), .wb_rst_i(b_rst), .sys_rst_req_i(b_sreq), .core_rst_req_i(b_req),
    .sys_rst_o(b_sys), .core_rst_o(b_core), .busy_o(b_busy), .cur_core_o(b_cur),
    .all_running_o(b_allrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_sys"},    a_sys,    1);
    chk({tag, "_core"},   a_core,   2'b11);
    chk({tag, "_busy"},   a_busy,   1);
    chk({tag, "_cur"},    a_cur,    0);
    chk({tag, "_allrun"}, a_allrun, 0);
  endtask

  // Power-on timing for the default instance; edge n = n-th edge after release.
  task automatic seq_a(input int ncyc, input int req_at);
    for (int n = 1; n <= ncyc; n++) begin
      a_req = (n == req_at) ? 2'b11 : 2'b00;
      tick();
      chk($sformatf("a_sys@%0d", n),    a_sys,    n < 50);
      chk($sformatf("a_core@%0d", n),   a_core,   {n < 58, n < 54});
      chk($sformatf("a_busy@%0d", n),   a_busy,   n < 58);
      chk($sformatf("a_allrun@%0d", n), a_allrun, n >= 58);
      chk($sformatf("a_cur@%0d", n),    a_cur,    (n < 54) ? 0 : 1);
    end
    a_req = 2'b00;
  endtask

  initial begin
    logic [7:0] e;
    a_rst = 1; a_sreq = 0; a_req = 0;
    b_rst = 1; b_sreq = 0; b_req = 0;
    repeat (10) tick();
    chk_a_reset("a_por");

    a_rst = 0;
    seq_a(60, 0);

    // Single-core re-reset on core 1.
    a_req = 2'b10;
    for (int j = 0; j < 10; j++) begin
      tick();
      a_req = 2'b00;
      chk($sformatf("rr_core@%0d", j),   a_core,   {j < 8, 1'b0});
      chk($sformatf("rr_allrun@%0d", j), a_allrun, j >= 8);
    end

    // Both cores, then core 0 extended at E+5.
    a_req = 2'b11;
    for (int j = 0; j < 16; j++) begin
      tick();
      a_req = (j == 4) ? 2'b01 : 2'b00;
      chk($sformatf("ext_core@%0d", j),   a_core,   {j < 8, j < 13});
      chk($sformatf("ext_allrun@%0d", j), a_allrun, j >= 13);
    end

    // Global request together with a core request; global wins.
    a_sreq = 1; a_req = 2'b01;
    tick();
    a_sreq = 0; a_req = 2'b00;
    chk_a_reset("a_greq");
    seq_a(51, 10);

    // Reset sampled at edge 52, mid-stagger.
    a_rst = 1;
    tick();
    a_rst = 0;
    chk_a_reset("a_mid");
    seq_a(60, 0);

    // Eight cores, one-cycle hold and stagger.
    b_rst = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      for (int k = 0; k < 8; k++) e[k] = (n < 2 + k);
      chk($sformatf("b_sys@%0d", n),    b_sys,    0);
      chk($sformatf("b_core@%0d", n),   b_core,   e);
      chk($sformatf("b_cur@%0d", n),    b_cur,    (n < 2) ? 0 : ((n - 1 > 7) ? 7 : n - 1));
      chk($sformatf("b_busy@%0d", n),   b_busy,   n < 9);
      chk($sformatf("b_allrun@%0d", n), b_allrun, n >= 9);
    end

    b_req = 8'h81;
    for (int j = 0; j < 5; j++) begin
      tick();
      b_req = 8'h00;
      chk($sformatf("b_rr_core@%0d", j),   b_core,   (j < 3) ? 8'h81 : 8'h00);
      chk($sformatf("b_rr_allrun@%0d", j), b_allrun, j >= 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
